instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
Fetch controller between the PC and a byte-wide instruction memory. Issues four byte reads per instruction with a req/ack handshake and assembles them little-endian into a 32-bit word. Presents the word to decode with a valid/ready handshake, holds it under back-pressure, and advances the PC by 4. Branch redirects abort the current fetch and restart at the target.

Parameters:
ADDR_WIDTH, 64, width of PC and memory address
INSTR_WIDTH, 32, assembled instruction width; fixed at 4 bytes
RESET_PC, 0, PC loaded on reset

Ports:
clk  input  1  clock, rising edge
resetN  input  1  asynchronous active-low reset
memReq  output  1  byte read request, held until memAck
memAddr  output  ADDR_WIDTH  byte address = pc + byteIdx
memAck  input  1  memory samples memAddr and returns memData in this cycle
memData  input  8  byte read data, valid when memReq & memAck
instr  output  INSTR_WIDTH  assembled instruction
instrPc  output  ADDR_WIDTH  address of instr
instrValid  output  1  instr/instrPc valid
instrReady  input  1  decode accepts when instrValid & instrReady
redirect  input  1  branch taken; single-cycle pulse
redirectPc  input  ADDR_WIDTH  new fetch address, sampled when redirect=1
stall  input  1  suppresses new memReq; does not affect a held instr

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, byteIdx=0, instr=0, instrPc=0, instrValid=0, memReq=0, memAddr=RESET_PC.
- States:
  - FETCH: memReq=!stall. memAddr=pc+byteIdx (mod 2^ADDR_WIDTH). On memReq & memAck, memData is written into instr byte lane byteIdx and byteIdx increments. On the ack with byteIdx=3: instrPc<=pc, instrValid<=1, pc<=pc+4, byteIdx<=0, go to HOLD.
  - HOLD: memReq=0, instr stable. On instrValid & instrReady: instrValid<=0 and go to FETCH. First memReq is asserted the next cycle (no prefetch).
- Latency: minimum 4 cycles from entering FETCH to instrValid (memAck tied high). Peak throughput is one instruction per 5 cycles.
- Partial bytes are never visible: instrValid is only asserted after all 4 bytes.
- Redirect, highest priority, any state:
  - Next cycle: pc=redirectPc, byteIdx=0, instrValid=0, state=FETCH.
  - A memAck in the redirect cycle is discarded.
  - An instr held in HOLD is dropped even if instrReady=1 in that cycle; decode must not count it as accepted.
- Stall: in FETCH, memReq is forced low and byteIdx holds. Stall in HOLD has no effect.
- PC wrap: pc+4 and pc+byteIdx wrap modulo 2^ADDR_WIDTH with no flag.
- redirectPc alignment is not checked; fetch proceeds from any byte address.
- Reset mid-fetch: immediate return to reset values; any in-progress bytes are lost.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds three outputs, each 32 bits, reset to 0 and wrapping on overflow:
  - fetchCount: +1 per accepted instruction (instrValid & instrReady & !redirect)
  - redirectCount: +1 per redirect cycle
  - stallCount: +1 per cycle in FETCH with stall=1, or in HOLD with instrReady=0
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, memAck=1, memData bytes 0x23,0x01,0x02,0x03, instrReady=1: memAddr 0,1,2,3; instrValid in cycle 4 with instr=0x03020123, instrPc=0; next fetch at memAddr=4.
- memAck low 2 cycles on byte 1: memReq and memAddr=1 held; instr correct; instrValid delayed by 2 cycles.
- instrReady=0 for 5 cycles after valid: instr and instrPc stable, memReq=0. Release: one acceptance, then fetch from pc+4.
- Redirect to 0x100 coincident with byte-2 memAck: that byte is discarded, next memAddr=0x100, and the old partial instruction never appears.
- Redirect while in HOLD with instrReady=1: instrValid drops, no acceptance counted, fetch restarts at the target.
- RESET_PC=0xFFFF_FFFF_FFFF_FFFC: memAddr sequence ...FC..FF, then 0x0; no hang. With FETCH_PERF_CNT_EN: 10 accepted instructions and 2 redirects give fetchCount=10 and redirectCount=2.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// Byte-serial instruction fetch: four req/ack byte reads assembled little-endian into one word,
// handed to decode over valid/ready. Optional perf counters behind `FETCH_PERF_CNT_EN.
module instr_fetch_sequencer #(
    parameter int unsigned            ADDR_WIDTH  = 64,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   resetN,
    output logic                   memReq,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    input  logic                   memAck,
    input  logic [7:0]             memData,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instrPc,
    output logic                   instrValid,
    input  logic                   instrReady,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirectPc,
    input  logic                   stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetchCount,
    output logic [31:0]            redirectCount,
    output logic [31:0]            stallCount
`endif
);

    typedef enum logic {StFetch, StHold} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [1:0]              byte_idx_q;
    logic                    byte_ack;
    logic                    accept;

    // Request is a live function of stall so a stalled cycle never issues a read.
    assign memReq   = resetN & (state_q == StFetch) & ~stall;
    assign memAddr  = pc_q + ADDR_WIDTH'(byte_idx_q);
    assign byte_ack = memReq & memAck;
    assign accept   = instrValid & instrReady & ~redirect;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            byte_idx_q <= 2'd0;
            instr      <= '0;
            instrPc    <= '0;
            instrValid <= 1'b0;
        end else if (redirect) begin
            // Redirect outranks everything: a coincident ack or acceptance is dropped.
            state_q    <= StFetch;
            pc_q       <= redirectPc;
            byte_idx_q <= 2'd0;
            instrValid <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (byte_ack) begin
                        instr[{byte_idx_q, 3'b000} +: 8] <= memData;
                        if (byte_idx_q == 2'd3) begin
                            instrPc    <= pc_q;
                            instrValid <= 1'b1;
                            pc_q       <= pc_q + ADDR_WIDTH'(4);
                            byte_idx_q <= 2'd0;
                            state_q    <= StHold;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                StHold: begin
                    if (instrReady) begin
                        instrValid <= 1'b0;
                        state_q    <= StFetch;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = ((state_q == StFetch) & stall) | ((state_q == StHold) & ~instrReady);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetchCount    <= 32'd0;
            redirectCount <= 32'd0;
            stallCount    <= 32'd0;
        end else begin
            if (accept) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (redirect) begin
                redirectCount <= redirectCount + 32'd1;
            end
            if (stall_cycle) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed scenarios, randomized traffic against a
// transaction-level model, and a second instance started near the top of the address space.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        resetN, resetN2;
    int          vectors = 0;
    int          miscompares = 0;

    // Main instance
    logic        memReq, memAck, instrValid, instrReady, redirect, stall;
    logic [63:0] memAddr, instrPc, redirectPc;
    logic [7:0]  memData;
    logic [31:0] instr;
    logic        use_tbl;

    // Wrap instance
    logic        memReq2, instrValid2, instrReady2, redirect2;
    logic [63:0] memAddr2, instrPc2, redirectPc2;
    logic [7:0]  memData2;
    logic [31:0] instr2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount, redirectCount, stallCount;
    logic [31:0] fetchCount2, redirectCount2, stallCount2;
`endif

    // Model perf counters
    logic [31:0] m_fc, m_rc, m_sc;
    logic        perf_on;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [7:0] m;
        m = a[7:0] * 8'd29;
        return m ^ a[15:8] ^ a[63:56] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] tbl_byte(input logic [63:0] a);
        logic [7:0] t [4];
        t[0] = 8'h23; t[1] = 8'h01; t[2] = 8'h02; t[3] = 8'h03;
        return t[a[1:0]];
    endfunction

    function automatic logic [31:0] word(input logic [63:0] pc);
        return {mem_byte(pc + 64'd3), mem_byte(pc + 64'd2), mem_byte(pc + 64'd1), mem_byte(pc)};
    endfunction

    assign memData  = use_tbl ? tbl_byte(memAddr) : mem_byte(memAddr);
    assign memData2 = mem_byte(memAddr2);

    instr_fetch_sequencer #(
        .ADDR_WIDTH (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (64'h0)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memAck    (memAck),
        .memData   (memData),
        .instr     (instr),
        .instrPc   (instrPc),
        .instrValid(instrValid),
        .instrReady(instrReady),
        .redirect  (redirect),
        .redirectPc(redirectPc),
        .stall     (stall)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount   (fetchCount),
        .redirectCount(redirectCount),
        .stallCount   (stallCount)
`endif
    );

    instr_fetch_sequencer #(
        .ADDR_WIDTH (64),
        .INSTR_WIDTH(32),
        .RESET_PC   (64'hFFFF_FFFF_FFFF_FFFC)
    ) dut_wrap (
        .clk       (clk),
        .resetN    (resetN2),
        .memReq    (memReq2),
        .memAddr   (memAddr2),
        .memAck    (1'b1),
        .memData   (memData2),
        .instr     (instr2),
        .instrPc   (instrPc2),
        .instrValid(instrValid2),
        .instrReady(instrReady2),
        .redirect  (redirect2),
        .redirectPc(redirectPc2),
        .stall     (1'b0)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount   (fetchCount2),
        .redirectCount(redirectCount2),
        .stallCount   (stallCount2)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the main instance: compare perf counters for all completed cycles, drive new
    // inputs, then fold this cycle into the counter model.
    task automatic step(input logic ack, input logic rdy, input logic stl, input logic rd,
                        input logic [63:0] rpc);
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        if (perf_on) begin
            chk("fetchCount", 64'(fetchCount), 64'(m_fc));
            chk("redirectCount", 64'(redirectCount), 64'(m_rc));
            chk("stallCount", 64'(stallCount), 64'(m_sc));
        end
`endif
        memAck = ack; instrReady = rdy; stall = stl; redirect = rd; redirectPc = rpc;
        #1;
        if (perf_on) begin
            if (instrValid && instrReady && !redirect) m_fc = m_fc + 32'd1;
            if (redirect) m_rc = m_rc + 32'd1;
            if (instrValid ? !instrReady : stall) m_sc = m_sc + 32'd1;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] exp_pc, base;
        int          idle;

        resetN = 1'b0; resetN2 = 1'b0; use_tbl = 1'b1; perf_on = 1'b0;
        memAck = 1'b0; instrReady = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
        instrReady2 = 1'b1; redirect2 = 1'b0; redirectPc2 = '0;
        m_fc = '0; m_rc = '0; m_sc = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_memReq", 64'(memReq), 64'd0);
        chk("rst_memAddr", memAddr, 64'd0);
        chk("rst_valid", 64'(instrValid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instrPc", instrPc, 64'd0);
        chk("rst2_memAddr", memAddr2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("rst2_memReq", 64'(memReq2), 64'd0);
        resetN  = 1'b1;
        perf_on = 1'b1;

        // Basic fetch with table bytes
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
            chk("t1_req", 64'(memReq), 64'd1);
            chk("t1_addr", memAddr, 64'(i));
            chk("t1_novalid", 64'(instrValid), 64'd0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t1_valid", 64'(instrValid), 64'd1);
        chk("t1_instr", 64'(instr), 64'h0302_0123);
        chk("t1_pc", instrPc, 64'd0);
        chk("t1_hold_noreq", 64'(memReq), 64'd0);
        use_tbl = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t1_next_addr", memAddr, 64'd4);
        chk("t1_next_req", 64'(memReq), 64'd1);

        // Ack withheld two cycles on byte 1
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            chk("t2_req_held", 64'(memReq), 64'd1);
            chk("t2_addr_held", memAddr, 64'd5);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t2_addr5", memAddr, 64'd5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t2_addr6", memAddr, 64'd6);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t2_addr7", memAddr, 64'd7);
        chk("t2_not_yet", 64'(instrValid), 64'd0);

        // Back-pressure for 5 cycles, stall toggling in HOLD
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'(i % 2), 1'b0, 64'd0);
            chk("t3_valid", 64'(instrValid), 64'd1);
            chk("t3_instr", 64'(instr), 64'(word(64'd4)));
            chk("t3_pc", instrPc, 64'd4);
            chk("t3_noreq", 64'(memReq), 64'd0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t3_accept_valid", 64'(instrValid), 64'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t3_after_valid", 64'(instrValid), 64'd0);
        chk("t3_after_addr", memAddr, 64'd8);

        // Redirect coincident with byte-2 ack
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t4_addr9", memAddr, 64'd9);
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h100);
        chk("t4_addr10", memAddr, 64'd10);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
            chk("t4_addr_tgt", memAddr, 64'h100 + 64'(i));
            chk("t4_no_partial", 64'(instrValid), 64'd0);
        end

        // Redirect while holding with instrReady=1
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h200);
        chk("t5_valid", 64'(instrValid), 64'd1);
        chk("t5_pc", instrPc, 64'h100);
        chk("t5_instr", 64'(instr), 64'(word(64'h100)));
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("t5_dropped", 64'(instrValid), 64'd0);
        chk("t5_addr", memAddr, 64'h200);
        chk("t5_req", 64'(memReq), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_fetchCount", 64'(fetchCount), 64'd2);
        chk("t5_redirectCount", 64'(redirectCount), 64'd2);
        chk("t5_stallCount", 64'(stallCount), 64'd5);
`endif

        // Randomized traffic against the transaction model
        exp_pc = 64'h200;
        idle = 0;
        for (int n = 0; n < 2000; n++) begin
            logic        rd;
            logic [63:0] rpc;
            rd  = ($urandom_range(0, 39) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                              : {$urandom, $urandom};
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) == 0), rd, rpc);
            if (stall) chk("r_stall_gates_req", 64'(memReq), 64'd0);
            if (memReq) begin
                chk("r_req_excl_valid", 64'(instrValid), 64'd0);
                chk("r_addr_window", 64'((memAddr - exp_pc) < 64'd4), 64'd1);
            end
            if (instrValid) begin
                chk("r_pc", instrPc, exp_pc);
                chk("r_instr", 64'(instr), 64'(word(exp_pc)));
            end
            idle = (instrValid || redirect) ? 0 : idle + 1;
            if (idle == 300) chk("r_liveness", 64'(idle), 64'd0);
            if (redirect) exp_pc = redirectPc;
            else if (instrValid && instrReady) exp_pc = exp_pc + 64'd4;
        end

        // Asynchronous reset mid-traffic
        @(negedge clk);
        resetN  = 1'b0;
        perf_on = 1'b0;
        #1;
        chk("arst_req", 64'(memReq), 64'd0);
        chk("arst_addr", memAddr, 64'd0);
        chk("arst_valid", 64'(instrValid), 64'd0);
        chk("arst_pc", instrPc, 64'd0);
        chk("arst_instr", 64'(instr), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_fetchCount", 64'(fetchCount), 64'd0);
`endif

        // Address wrap from RESET_PC near the top of the space
        @(negedge clk);
        resetN2 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            base = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * (i / 5));
            if (i % 5 == 4) begin
                chk("wrap_valid", 64'(instrValid2), 64'd1);
                chk("wrap_pc", instrPc2, base);
                chk("wrap_instr", 64'(instr2), 64'(word(base)));
            end else begin
                chk("wrap_req", 64'(memReq2), 64'd1);
                chk("wrap_addr", memAddr2, base + 64'(i % 5));
            end
            @(negedge clk);
        end
        redirect2 = 1'b1; redirectPc2 = 64'h40;
        @(negedge clk);
        redirectPc2 = 64'h80;
        @(negedge clk);
        redirect2 = 1'b0;
        #1;
        chk("wrap_redir_addr", memAddr2, 64'h80);
`ifdef FETCH_PERF_CNT_EN
        chk("wrap_fetchCount", 64'(fetchCount2), 64'd10);
        chk("wrap_redirectCount", 64'(redirectCount2), 64'd2);
        chk("wrap_stallCount", 64'(stallCount2), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
